// File: rtl/i2c_slave_regfile.sv
// I2C target exposing a NUM_REGS x 8 register file with an auto-incrementing pointer.
// Optional SCL/SDA glitch filter is enabled by defining I2C_GLITCH_FILT_EN.
module i2c_slave_regfile #(
    parameter logic [6:0] DEV_ADDR    = 7'h51,
    parameter int         NUM_REGS    = 16,
    parameter int         SYNC_STAGES = 2,
    parameter int         FILT_LEN    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  scl_in,
    input  logic                  sda_in,
    output logic                  sda_oe,
    output logic [NUM_REGS*8-1:0] regs_flat,
    output logic                  wr_strobe,
    output logic [7:0]            wr_idx,
    output logic                  busy
);

    localparam int PW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR,
        S_ACK_A,
        S_PTR,
        S_ACK_P,
        S_WDATA,
        S_ACK_W,
        S_RDATA,
        S_MACK,
        S_WAIT
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_r;
    logic                   sda_r;
    logic                   scl_s;
    logic                   sda_s;
    logic                   scl_q;
    logic                   sda_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
        end
    end

    assign scl_r = scl_sync[SYNC_STAGES-1];
    assign sda_r = sda_sync[SYNC_STAGES-1];

`ifdef I2C_GLITCH_FILT_EN
    localparam int FW = $clog2(FILT_LEN + 1);

    logic [1:0]    raw;
    logic [1:0]    filt_q;
    logic [FW-1:0] filt_cnt [2];

    assign raw = {scl_r, sda_r};

    // A level is accepted only after FILT_LEN consecutive cycles of disagreement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q      <= '1;
            filt_cnt[0] <= '0;
            filt_cnt[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (raw[i] == filt_q[i]) begin
                    filt_cnt[i] <= '0;
                end else if (filt_cnt[i] == FW'(FILT_LEN - 1)) begin
                    filt_q[i]   <= raw[i];
                    filt_cnt[i] <= '0;
                end else begin
                    filt_cnt[i] <= filt_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign scl_s = filt_q[1];
    assign sda_s = filt_q[0];
`else
    logic unused_filt;

    assign unused_filt = (FILT_LEN > 0);
    assign scl_s       = scl_r;
    assign sda_s       = sda_r;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_q <= 1'b1;
            sda_q <= 1'b1;
        end else begin
            scl_q <= scl_s;
            sda_q <= sda_s;
        end
    end

    logic scl_rise;
    logic scl_fall;
    logic ev_start;
    logic ev_stop;

    assign scl_rise = scl_s & ~scl_q;
    assign scl_fall = ~scl_s & scl_q;
    assign ev_start = scl_s & scl_q & sda_q & ~sda_s;
    assign ev_stop  = scl_s & scl_q & ~sda_q & sda_s;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] cnt;
    logic [3:0] cnt_nxt;
    logic [7:0] sh;
    logic [7:0] ptr;
    logic [7:0] ptr_nxt;
    logic [7:0] ptr_wrap;
    logic       rw;
    logic       rw_nxt;
    logic       mack_ok;
    logic       mack_nxt;
    logic       oe_nxt;
    logic       busy_nxt;
    logic       wr_en;
    logic       cnt_full;
    logic       rx_state;
    logic       addr_hit;
    logic       ptr_ok;
    logic [7:0] rd_byte;
    logic [7:0] regs [NUM_REGS];

    assign cnt_full = (cnt == 4'd8);
    assign rx_state = (state == S_ADDR) || (state == S_PTR) || (state == S_WDATA);
    assign addr_hit = (sh[7:1] == DEV_ADDR);
    assign ptr_ok   = ({1'b0, sh} < 9'(NUM_REGS));
    assign ptr_wrap = (ptr == 8'(NUM_REGS - 1)) ? 8'd0 : ptr + 8'd1;
    assign rd_byte  = regs[ptr[PW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (1'b1)
            ev_start: state_nxt = S_ADDR;
            ev_stop:  state_nxt = S_IDLE;
            default: begin
                unique case (state)
                    S_ADDR: begin
                        if (scl_fall && cnt_full) begin
                            state_nxt = addr_hit ? S_ACK_A : S_IDLE;
                        end
                    end
                    S_ACK_A: begin
                        if (scl_fall) begin
                            state_nxt = rw ? S_RDATA : S_PTR;
                        end
                    end
                    S_PTR: begin
                        if (scl_fall && cnt_full) begin
                            state_nxt = ptr_ok ? S_ACK_P : S_IDLE;
                        end
                    end
                    S_ACK_P, S_ACK_W: begin
                        if (scl_fall) begin
                            state_nxt = S_WDATA;
                        end
                    end
                    S_WDATA: begin
                        if (scl_fall && cnt_full) begin
                            state_nxt = S_ACK_W;
                        end
                    end
                    S_RDATA: begin
                        if (scl_fall && cnt_full) begin
                            state_nxt = S_MACK;
                        end
                    end
                    S_MACK: begin
                        if (scl_rise && sda_s) begin
                            state_nxt = S_WAIT;
                        end else if (scl_fall && mack_ok) begin
                            state_nxt = S_RDATA;
                        end
                    end
                    default: state_nxt = state;
                endcase
            end
        endcase
    end

    always_comb begin
        oe_nxt   = sda_oe;
        busy_nxt = busy;
        cnt_nxt  = cnt;
        ptr_nxt  = ptr;
        rw_nxt   = rw;
        mack_nxt = mack_ok;
        wr_en    = 1'b0;
        unique case (1'b1)
            ev_start: begin
                oe_nxt   = 1'b0;
                cnt_nxt  = 4'd0;
                mack_nxt = 1'b0;
            end
            ev_stop: begin
                oe_nxt   = 1'b0;
                busy_nxt = 1'b0;
                cnt_nxt  = 4'd0;
                mack_nxt = 1'b0;
            end
            default: begin
                if (rx_state && scl_rise && !cnt_full) begin
                    cnt_nxt = cnt + 4'd1;
                end
                unique case (state)
                    S_ADDR: begin
                        if (scl_fall && cnt_full) begin
                            cnt_nxt = 4'd0;
                            if (addr_hit) begin
                                oe_nxt   = 1'b1;
                                busy_nxt = 1'b1;
                                rw_nxt   = sh[0];
                            end else begin
                                busy_nxt = 1'b0;
                            end
                        end
                    end
                    S_ACK_A: begin
                        if (scl_fall) begin
                            cnt_nxt = rw ? 4'd1 : 4'd0;
                            oe_nxt  = rw ? ~rd_byte[7] : 1'b0;
                        end
                    end
                    S_PTR: begin
                        if (scl_fall && cnt_full) begin
                            cnt_nxt = 4'd0;
                            if (ptr_ok) begin
                                ptr_nxt = sh;
                                oe_nxt  = 1'b1;
                            end else begin
                                busy_nxt = 1'b0;
                            end
                        end
                    end
                    S_ACK_P, S_ACK_W: begin
                        if (scl_fall) begin
                            oe_nxt  = 1'b0;
                            cnt_nxt = 4'd0;
                        end
                    end
                    S_WDATA: begin
                        if (scl_fall && cnt_full) begin
                            wr_en   = 1'b1;
                            ptr_nxt = ptr_wrap;
                            oe_nxt  = 1'b1;
                            cnt_nxt = 4'd0;
                        end
                    end
                    S_RDATA: begin
                        if (scl_fall) begin
                            if (cnt_full) begin
                                oe_nxt  = 1'b0;
                                cnt_nxt = 4'd0;
                            end else begin
                                oe_nxt  = ~rd_byte[3'(4'd7 - cnt)];
                                cnt_nxt = cnt + 4'd1;
                            end
                        end
                    end
                    S_MACK: begin
                        // Pointer advances on the ACK rise so the next fall drives the new byte.
                        if (scl_rise && !sda_s) begin
                            mack_nxt = 1'b1;
                            ptr_nxt  = ptr_wrap;
                        end else if (scl_fall && mack_ok) begin
                            mack_nxt = 1'b0;
                            oe_nxt   = ~rd_byte[7];
                            cnt_nxt  = 4'd1;
                        end
                    end
                    S_WAIT: oe_nxt = 1'b0;
                    default: oe_nxt = sda_oe;
                endcase
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= 4'd0;
            sh        <= 8'd0;
            ptr       <= 8'd0;
            rw        <= 1'b0;
            mack_ok   <= 1'b0;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            wr_strobe <= 1'b0;
            wr_idx    <= 8'd0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= 8'd0;
            end
        end else begin
            cnt       <= cnt_nxt;
            ptr       <= ptr_nxt;
            rw        <= rw_nxt;
            mack_ok   <= mack_nxt;
            sda_oe    <= oe_nxt;
            busy      <= busy_nxt;
            wr_strobe <= wr_en;
            if (scl_rise) begin
                sh <= {sh[6:0], sda_s};
            end
            if (wr_en) begin
                wr_idx             <= ptr;
                regs[ptr[PW-1:0]]  <= sh;
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_flat[g*8 +: 8] = regs[g];
    end

endmodule
